// File: rtl/mem_ctr_pkg.sv
// Shared constants, C2 command encodings and controller state for the main-memory model.
package mem_ctr_pkg;
   localparam int ADDR2_BUS_SIZE  = 15;
   localparam int DATA2_BUS_SIZE  = 16;
   localparam int CTR2_BUS_SIZE   = 2;
   localparam int CACHE_LINE_SIZE = 16;
   localparam int MEM_SIZE        = 1 << (ADDR2_BUS_SIZE + 4);
   localparam int MEM_LATENCY     = 100;
   localparam int LINE_WORDS      = CACHE_LINE_SIZE * 8 / DATA2_BUS_SIZE;
   localparam int LAT_W           = $clog2(MEM_LATENCY);

   localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = 2'd0;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 2'd1;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2'd2;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WRITE_RX, ST_WAIT, ST_READ_TX, ST_WRITE_ACK
   } state_e;
endpackage

// File: rtl/mem_line_array.sv
// Byte storage with an atomic whole-line write port and a combinational 16-bit word read port.
module mem_line_array
   import mem_ctr_pkg::*;
(
   input  logic                          clk,
   input  logic                          we,
   input  logic [ADDR2_BUS_SIZE-1:0]     waddr,
   input  logic [CACHE_LINE_SIZE*8-1:0]  wdata,
   input  logic [ADDR2_BUS_SIZE+2:0]     raddr,
   output logic [DATA2_BUS_SIZE-1:0]     rdata
);
   // Contents are deliberately not reset; they survive controller resets.
   logic [7:0] mem_q [MEM_SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < CACHE_LINE_SIZE; i++)
            mem_q[{waddr, 4'(i)}] <= wdata[8*i +: 8];
      end
   end

   // Low byte of a bus word is the lower byte address.
   assign rdata = {mem_q[{raddr, 1'b1}], mem_q[{raddr, 1'b0}]};
endmodule

// File: rtl/mem_ctr.sv
// Main-memory controller on the A2/D2/C2 bus: whole-line reads and writes with fixed latency.
module mem_ctr
   import mem_ctr_pkg::*;
(
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [ADDR2_BUS_SIZE-1:0]  A2,
   inout  wire  [DATA2_BUS_SIZE-1:0]  D2,
   inout  wire  [CTR2_BUS_SIZE-1:0]   C2,
   input  logic                       M_DUMP
);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

   state_e                                     state_q, state_d;
   logic [ADDR2_BUS_SIZE-1:0]                  addr_q, addr_d;
   logic                                       is_read_q, is_read_d;
   logic [2:0]                                 wc_q, wc_d;
   logic [LAT_W-1:0]                           lat_q, lat_d;
   logic [LINE_WORDS-1:0][DATA2_BUS_SIZE-1:0]  line_q, line_d;
   logic                                       commit;
   logic [DATA2_BUS_SIZE-1:0]                  rd_word;
   logic                                       d2_oe, c2_oe;
   logic [CTR2_BUS_SIZE-1:0]                   c2_out;

   // M_DUMP is a simulation debug hook with no state effect; nothing here consumes it.
   logic m_dump_unused;
   assign m_dump_unused = M_DUMP;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      is_read_d = is_read_q;
      wc_d      = wc_q;
      lat_d     = lat_q;
      line_d    = line_q;
      commit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (C2 == C2_READ_LINE) begin
               addr_d    = A2;
               is_read_d = 1'b1;
               lat_d     = LAT_INIT;
               state_d   = ST_WAIT;
            end else if (C2 == C2_WRITE_LINE) begin
               addr_d    = A2;
               is_read_d = 1'b0;
               line_d[0] = D2;
               wc_d      = 3'd1;
               state_d   = ST_WRITE_RX;
            end
         end
         ST_WRITE_RX: begin
            line_d[wc_q] = D2;
            wc_d         = wc_q + 3'd1;
            // Word 7 goes straight from the bus into the commit so the line lands in one edge.
            if (wc_q == 3'd7) begin
               commit  = 1'b1;
               lat_d   = LAT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               wc_d    = 3'd0;
               state_d = is_read_q ? ST_READ_TX : ST_WRITE_ACK;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_READ_TX: begin
            wc_d = wc_q + 3'd1;
            if (wc_q == 3'd7) state_d = ST_IDLE;
         end
         ST_WRITE_ACK: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         is_read_q <= 1'b0;
         wc_q      <= '0;
         lat_q     <= '0;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         is_read_q <= is_read_d;
         wc_q      <= wc_d;
         lat_q     <= lat_d;
         line_q    <= line_d;
      end
   end

   mem_line_array u_array (
      .clk   (CLK),
      .we    (commit),
      .waddr (addr_q),
      .wdata ({D2, line_q[LINE_WORDS-2:0]}),
      .raddr ({addr_q, wc_q}),
      .rdata (rd_word)
   );

   // Enables decode straight from the state flop, so reset releases the bus without a clock.
   assign d2_oe  = (state_q == ST_READ_TX);
   assign c2_oe  = (state_q == ST_WAIT) || (state_q == ST_READ_TX) || (state_q == ST_WRITE_ACK);
   assign c2_out = (state_q == ST_WAIT) ? C2_NOP : C2_RESPONSE;

   assign D2 = d2_oe ? rd_word : 'z;
   assign C2 = c2_oe ? c2_out  : 'z;
endmodule

// File: tb/tb_mem_ctr.sv
// Directed bench for mem_ctr: latency, line data, top line and resets in each busy phase.
module tb_mem_ctr;
   import mem_ctr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_dump = 1'b0;
   logic [14:0] a2 = '0;
   logic [15:0] d2_drv = '0;
   logic        d2_en = 1'b0;
   logic [1:0]  c2_drv = '0;
   logic        c2_en = 1'b0;
   // Released D2 reads all-ones; released C2 reads NOP so an idle bus never looks like a command.
   tri1 [15:0]  d2;
   tri0 [1:0]   c2;

   assign d2 = d2_en ? d2_drv : 16'hzzzz;
   assign c2 = c2_en ? c2_drv : 2'bzz;

   int n_tests = 0;
   int n_fail  = 0;
   int resp_at, resp_cnt, resp_last, bus_bad;
   logic [7:0][15:0] rd_w;

   always #5 clk = ~clk;

   mem_ctr dut (.CLK(clk), .RESET(rst_n), .A2(a2), .D2(d2), .C2(c2), .M_DUMP(m_dump));

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic drive_write(input logic [14:0] a, input logic [7:0][15:0] w);
      a2 = a; c2_drv = C2_WRITE_LINE; c2_en = 1'b1; d2_drv = w[0]; d2_en = 1'b1;
      tick;
      for (int i = 1; i < 8; i++) begin
         d2_drv = w[3'(i)];
         tick;
      end
      c2_en = 1'b0; d2_en = 1'b0;
   endtask

   task automatic drive_read(input logic [14:0] a);
      a2 = a; c2_drv = C2_READ_LINE; c2_en = 1'b1;
      tick;
      c2_en = 1'b0;
   endtask

   // Observes n cycles (k = 0 is the cycle after the most recent edge).
   task automatic watch(input int n);
      resp_at = -1; resp_cnt = 0; resp_last = -1; bus_bad = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (c2 == C2_RESPONSE) begin
            if (resp_cnt < 8) rd_w[resp_cnt[2:0]] = d2;
            if (resp_at < 0) resp_at = k;
            resp_last = k;
            resp_cnt++;
         end else if (c2 !== C2_NOP || d2 !== 16'hFFFF) begin
            bus_bad++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (c2 !== 2'b00) begin n_fail++; $display("FAIL reset_c2: got %0h want released", c2); end
      n_tests++; if (d2 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_d2: got %0h want released", d2); end
      rst_n = 1'b1;
      watch(20);
      n_tests++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL idle_resp: got %0d want 0", resp_cnt); end
      n_tests++; if (bus_bad !== 0) begin n_fail++; $display("FAIL idle_bus: got %0d busy cycles want 0", bus_bad); end
   endtask

   task automatic test_write_read;
      logic [7:0][15:0] w;
      for (int i = 0; i < 8; i++) w[3'(i)] = {8'((2*i+1)*17), 8'((2*i)*17)};
      drive_write(15'h0005, w);
      watch(120);
      n_tests++; if (resp_at !== 100) begin n_fail++; $display("FAIL wr_ack_at: got %0d want 100", resp_at); end
      n_tests++; if (resp_cnt !== 1) begin n_fail++; $display("FAIL wr_ack_cnt: got %0d want 1", resp_cnt); end
      n_tests++; if (bus_bad !== 0) begin n_fail++; $display("FAIL wr_bus: got %0d bad cycles want 0", bus_bad); end
      drive_read(15'h0005);
      watch(120);
      n_tests++; if (resp_at !== 100) begin n_fail++; $display("FAIL rd_first: got %0d want 100", resp_at); end
      n_tests++; if (resp_cnt !== 8) begin n_fail++; $display("FAIL rd_cnt: got %0d want 8", resp_cnt); end
      n_tests++; if (resp_last !== 107) begin n_fail++; $display("FAIL rd_last: got %0d want 107", resp_last); end
      n_tests++; if (bus_bad !== 0) begin n_fail++; $display("FAIL rd_bus: got %0d bad cycles want 0", bus_bad); end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (rd_w[3'(i)] !== w[3'(i)]) begin
            n_fail++; $display("FAIL rd_word%0d: got %h want %h", i, rd_w[3'(i)], w[3'(i)]);
         end
      end
   endtask

   task automatic test_top_line;
      logic [7:0][15:0] lo, hi;
      lo = {8{16'h5A5A}};
      hi = {8{16'hA5A5}};
      drive_write(15'h7FFE, lo); watch(120);
      drive_write(15'h7FFF, hi); watch(120);
      n_tests++; if (resp_cnt !== 1) begin n_fail++; $display("FAIL top_ack: got %0d want 1", resp_cnt); end
      drive_read(15'h7FFF); watch(120);
      n_tests++; if (resp_cnt !== 8) begin n_fail++; $display("FAIL top_cnt: got %0d want 8", resp_cnt); end
      n_tests++; if (rd_w !== hi) begin n_fail++; $display("FAIL top_data: got %h want %h", rd_w, hi); end
      drive_read(15'h7FFE); watch(120);
      n_tests++; if (rd_w !== lo) begin n_fail++; $display("FAIL below_top: got %h want %h", rd_w, lo); end
   endtask

   task automatic test_reset_wait;
      logic [7:0][15:0] w;
      for (int i = 0; i < 8; i++) w[3'(i)] = 16'hC000 + 16'(i);
      drive_write(15'h0100, w);
      watch(50);
      rst_n = 1'b0;
      #1;
      n_tests++; if (d2 !== 16'hFFFF) begin n_fail++; $display("FAIL rstw_d2: got %0h want released", d2); end
      tick; tick;
      rst_n = 1'b1;
      watch(100);
      n_tests++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL rstw_no_ack: got %0d want 0", resp_cnt); end
      n_tests++; if (bus_bad !== 0) begin n_fail++; $display("FAIL rstw_bus: got %0d want 0", bus_bad); end
      drive_read(15'h0100); watch(120);
      n_tests++; if (resp_at !== 100) begin n_fail++; $display("FAIL rstw_rd_at: got %0d want 100", resp_at); end
      n_tests++; if (rd_w !== w) begin n_fail++; $display("FAIL rstw_data: got %h want %h", rd_w, w); end
   endtask

   task automatic test_reset_write_rx;
      logic [7:0][15:0] w, wx;
      for (int i = 0; i < 8; i++) begin
         w[3'(i)]  = 16'h1200 + 16'(i);
         wx[3'(i)] = 16'hDE00 + 16'(i);
      end
      drive_write(15'h0200, w); watch(120);
      a2 = 15'h0200; c2_drv = C2_WRITE_LINE; c2_en = 1'b1; d2_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d2_drv = wx[3'(i)];
         tick;
      end
      rst_n = 1'b0; c2_en = 1'b0; d2_en = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      watch(20);
      n_tests++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL rstrx_no_ack: got %0d want 0", resp_cnt); end
      drive_read(15'h0200); watch(120);
      n_tests++; if (rd_w !== w) begin n_fail++; $display("FAIL rstrx_data: got %h want %h", rd_w, w); end
   endtask

   task automatic test_reset_read_tx;
      logic [7:0][15:0] w;
      for (int i = 0; i < 8; i++) w[3'(i)] = 16'h3000 + 16'(i * 257);
      drive_write(15'h0300, w); watch(120);
      drive_read(15'h0300);
      watch(102);
      n_tests++; if (c2 !== C2_RESPONSE || d2 !== w[2]) begin
         n_fail++; $display("FAIL rdtx_word2: got c2=%0h d2=%h want c2=1 d2=%h", c2, d2, w[2]);
      end
      rst_n = 1'b0;
      #1;
      n_tests++; if (c2 !== 2'b00 || d2 !== 16'hFFFF) begin
         n_fail++; $display("FAIL rdtx_release: got c2=%0h d2=%h want released", c2, d2);
      end
      tick; tick;
      rst_n = 1'b1;
      watch(10);
      n_tests++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL rdtx_aborted: got %0d want 0", resp_cnt); end
      drive_read(15'h0300); watch(120);
      n_tests++; if (resp_at !== 100) begin n_fail++; $display("FAIL rdtx_relat: got %0d want 100", resp_at); end
      n_tests++; if (resp_cnt !== 8) begin n_fail++; $display("FAIL rdtx_recnt: got %0d want 8", resp_cnt); end
      n_tests++; if (rd_w !== w) begin n_fail++; $display("FAIL rdtx_data: got %h want %h", rd_w, w); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_top_line;
      test_reset_wait;
      test_reset_write_rx;
      test_reset_read_tx;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_ctr.md
Name: mem_ctr

Overview:
- Main-memory model and controller sitting directly downstream of the cache, on the shared memory-side bus (A2/D2/C2).
- Serves whole-line READ_LINE and WRITE_LINE commands issued by the cache, with fixed access latency.
- Owns byte storage of MEM_SIZE bytes and drives the shared tri-state D2/C2 buses only while responding.

Parameters:
- MEM_SIZE, 524288, bytes of storage; equals 2^(ADDR2_BUS_SIZE+4).
- CACHE_LINE_SIZE, 16, bytes per line; a line moves as 8 bus words.
- ADDR2_BUS_SIZE, 15, line address width; byte address = {A2, 4'b0}.
- DATA2_BUS_SIZE, 16, bus word width; low byte = lower address.
- CTR2_BUS_SIZE, 2, command bus width.
- MEM_LATENCY, 100, cycles from command completion to first response cycle.
- _SEED, 225526, $random seed for initial contents (simulation only).

Ports:
- CLK  input  1  clock; all sampling on posedge.
- RESET  input  1  asynchronous, active-low reset.
- A2  input  ADDR2_BUS_SIZE  line address; valid on the command's first cycle.
- D2  inout  DATA2_BUS_SIZE  data words; memory drives only in READ_TX, else Z.
- C2  inout  CTR2_BUS_SIZE  command/response; memory drives only in WAIT/READ_TX/WRITE_ACK, else Z.
- M_DUMP  input  1  rising edge: sim-only $display of all bytes; no state effect.

Behaviour:
- Commands (package): C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3. In IDLE, X/Z/NOP/RESPONSE on C2 are ignored.
- Reset: RESET low → state IDLE, word counter 0, latency counter 0, D2/C2 released to Z immediately (not clock-gated). Storage array is NOT cleared; in-flight write data is discarded with nothing committed; in-flight read is aborted. Normal operation resumes on the first posedge with RESET high.
- States: IDLE, WRITE_RX, WAIT, READ_TX, WRITE_ACK.
- IDLE, edge sees READ_LINE: latch A2 and op=read; go to WAIT with lat=MEM_LATENCY-1.
- IDLE, edge sees WRITE_LINE: latch A2 and op=write; capture D2 as word 0; go to WRITE_RX with wc=1.
- WRITE_RX: capture D2 as word wc each edge; cache holds C2=WRITE_LINE. After the edge that captures word 7, commit all 16 bytes to the array atomically, then go to WAIT with lat=MEM_LATENCY-1.
- WAIT: drive C2=NOP, D2=Z. lat decrements each edge. When lat==0 at an edge: read → READ_TX with wc=0; write → WRITE_ACK.
- READ_TX: drive C2=RESPONSE and D2={mem[base+2wc+1], mem[base+2wc]}. Advance wc each edge. After wc==7, go to IDLE and release the bus.
- WRITE_ACK: drive C2=RESPONSE for exactly one cycle, then go to IDLE and release the bus.
- Latency: command edge at t0, with MEM_LATENCY=L.
  - Read: C2=NOP is driven from t0 through t0+L. Response words 0..7 are driven in the cycles after edges t0+L .. t0+L+7. Z resumes after edge t0+L+8.
  - Write: last word sampled at edge t0+7. RESPONSE is driven for the one cycle after edge t0+7+L.
- Address arithmetic: byte address is {A2,4'b0}, so there is no wrap. A2=2^ADDR2_BUS_SIZE-1 addresses the top line.
- No command queuing: a command on C2 outside IDLE is a protocol violation and is ignored. The bench flags it, not the RTL.
- Initial contents: mem[i] = $random(_SEED)>>16, truncated to 8 bits, for i in 0..MEM_SIZE-1.

Decomposition:
- Shared package holds: MEM_SIZE, CACHE_LINE_SIZE, ADDR2/DATA2/CTR2 bus sizes, MEM_LATENCY, the C2 command constants, and the state enum.
- One sub-module, mem_line_array: byte array with an atomic 16-byte line-write port, a combinational 16-bit word-read port, and the dump task.
- Tri-state enables and the FSM stay in mem_ctr.

Test Plan:
- Reset then idle: hold RESET low 3 cycles, C2 undriven by the bench → C2 and D2 read Z for 20 cycles; no response appears.
- Write then read: WRITE_LINE to A2=0x0005 with words 0x1100,0x3322,…,0xFFEE.
  - Expect C2=NOP during the wait, then one RESPONSE exactly 100 cycles after the word-7 edge, then Z.
  - Then READ_LINE to A2=0x0005 → the same 8 words in order, with C2=RESPONSE on 8 consecutive cycles starting exactly 100 cycles after the command edge.
- Top line: WRITE_LINE to A2=0x7FFF with all words 0xA5A5, then READ_LINE to 0x7FFF → 0xA5A5 ×8, and line 0x7FFE is unchanged.
- Reset during WAIT of a write: assert RESET 50 cycles after the word-7 edge.
  - Buses go Z asynchronously and no RESPONSE follows.
  - A later read of that line returns the committed data.
- Reset during WRITE_RX: assert RESET after word 3 → the line is unmodified on a later read (atomic commit).
- Reset during READ_TX: assert RESET after word 2 → D2/C2 go Z within the same cycle, and the next READ_LINE runs a full 100-cycle latency.
